// File: rtl/add_accum.sv
// ============================================================================
// add_accum : multi-operand accumulator over a valid/ready handshake; sticky
//             carry-out flag; optional saturation when ACC_SAT_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module add_accum #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              ovf,
  output logic              busy
);

  localparam int N_SLICES = DATA_W / 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_next;
  logic [DATA_W-1:0]  acc_r, acc_next;
  logic               ovf_r, ovf_next;
  logic [CNT_W-1:0]   rem_r, rem_next;

  logic [N_SLICES:0]  carry_w;
  logic [DATA_W-1:0]  add_sum_w;
  logic               accept_w;

  // Ripple adder assembled from 4-bit slices; carry_w[N_SLICES] is the carry-out.
  assign carry_w[0] = 1'b0;
  for (genvar i = 0; i < N_SLICES; i++) begin : g_slice
    assign {carry_w[i+1], add_sum_w[4*i +: 4]} =
        {1'b0, acc_r[4*i +: 4]} + {1'b0, in_data[4*i +: 4]} + {4'b0000, carry_w[i]};
  end

  assign accept_w  = in_valid && (state_r == ACC);
  assign in_ready  = (state_r == ACC);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign sum       = acc_r;
  assign ovf       = ovf_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= '0;
      ovf_r   <= 1'b0;
      rem_r   <= '0;
    end else begin
      state_r <= state_next;
      acc_r   <= acc_next;
      ovf_r   <= ovf_next;
      rem_r   <= rem_next;
    end
  end

  always_comb begin
    state_next = state_r;
    acc_next   = acc_r;
    ovf_next   = ovf_r;
    rem_next   = rem_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_next   = '0;
          ovf_next   = 1'b0;
          rem_next   = len;
          state_next = (len != '0) ? ACC : DONE;
        end
      end
      ACC: begin
        if (accept_w) begin
`ifdef ACC_SAT_EN
          acc_next = carry_w[N_SLICES] ? {DATA_W{1'b1}} : add_sum_w;
`else
          acc_next = add_sum_w;
`endif
          ovf_next = ovf_r | carry_w[N_SLICES];
          rem_next = rem_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (rem_r == {{(CNT_W-1){1'b0}}, 1'b1})
            state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_add_accum.sv
// ============================================================================
// tb_add_accum : directed self-checking bench for add_accum (DATA_W=4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_add_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] sum;
  logic       ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Observation vector: {busy, in_ready, out_valid, ovf, sum[3:0]}
  logic [7:0] obs;
  assign obs = {busy, in_ready, out_valid, ovf, sum};

  add_accum #(.DATA_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== 8'b0000_0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 8'b0000_0000);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 8'b0000_0000) begin
      errors++; $display("FAIL idle_after_reset: got %b expected %b", obs, 8'b0000_0000);
    end
  endtask

  task automatic test_basic_sum();
    start = 1'b1; len = 4'd3; tick(); start = 1'b0;
    checks++;
    if (obs !== 8'b1100_0000) begin
      errors++; $display("FAIL basic_enter_acc: got %b expected %b", obs, 8'b1100_0000);
    end
    in_valid = 1'b1;
    in_data = 4'd3; tick();
    in_data = 4'd4; tick();
    checks++;
    if (obs !== 8'b1100_0111) begin
      errors++; $display("FAIL basic_partial: got %b expected %b", obs, 8'b1100_0111);
    end
    in_data = 4'd5; tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== {4'b1010, 4'd12}) begin
      errors++; $display("FAIL basic_result: got %b expected %b", obs, {4'b1010, 4'd12});
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      errors++; $display("FAIL basic_idle: got %b expected %b", {busy, in_ready, out_valid}, 3'b000);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] exp2, exp3;
`ifdef ACC_SAT_EN
    exp2 = 4'd15; exp3 = 4'd15;
`else
    exp2 = 4'd2;  exp3 = 4'd3;
`endif
    start = 1'b1; len = 4'd2; tick(); start = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd9; tick();
    in_data = 4'd9; tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== {4'b1011, exp2}) begin
      errors++; $display("FAIL ovf_len2: got %b expected %b", obs, {4'b1011, exp2});
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    start = 1'b1; len = 4'd3; tick(); start = 1'b0;
    checks++;
    if (obs !== 8'b1100_0000) begin
      errors++; $display("FAIL ovf_cleared_on_start: got %b expected %b", obs, 8'b1100_0000);
    end
    in_valid = 1'b1;
    in_data = 4'd9; tick();
    in_data = 4'd9; tick();
    in_data = 4'd1; tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== {4'b1011, exp3}) begin
      errors++; $display("FAIL ovf_len3: got %b expected %b", obs, {4'b1011, exp3});
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    int ready_seen = 0;
    start = 1'b1; len = 4'd0; in_valid = 1'b1; in_data = 4'd7;
    tick(); start = 1'b0;
    if (in_ready) ready_seen++;
    checks++;
    if (obs !== 8'b1010_0000) begin
      errors++; $display("FAIL zero_len_result: got %b expected %b", obs, 8'b1010_0000);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0; in_valid = 1'b0;
    if (in_ready) ready_seen++;
    checks++;
    if (ready_seen !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_len_no_ready: got ready_seen=%0d busy=%b expected 0 0", ready_seen, busy);
    end
  endtask

  task automatic test_bubbles();
    start = 1'b1; len = 4'd2; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd5; tick();
    in_valid = 1'b0; in_data = 4'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 8'b1100_0101) begin
        errors++; $display("FAIL bubble_hold_%0d: got %b expected %b", i, obs, 8'b1100_0101);
      end
    end
    in_valid = 1'b1; in_data = 4'd6; tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== {4'b1010, 4'd11}) begin
      errors++; $display("FAIL bubble_result: got %b expected %b", obs, {4'b1010, 4'd11});
    end
  endtask

  // Continues from the DONE state left by test_bubbles (sum=11, ovf=0).
  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 4'd1; in_valid = 1'b1; in_data = 4'd1;
      tick();
      checks++;
      if (obs !== {4'b1010, 4'd11}) begin
        errors++; $display("FAIL backpressure_hold_%0d: got %b expected %b", i, obs, {4'b1010, 4'd11});
      end
    end
    in_valid = 1'b0;
    start = 1'b1; len = 4'd2; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      errors++; $display("FAIL start_ignored_on_take: got %b expected %b", {busy, in_ready, out_valid}, 3'b000);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; len = 4'd3; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd7; tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== 8'b1100_0111) begin
      errors++; $display("FAIL midrun_partial: got %b expected %b", obs, 8'b1100_0111);
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 4'd2; tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (obs !== 8'b0000_0000) begin
      errors++; $display("FAIL midrun_reset: got %b expected %b", obs, 8'b0000_0000);
    end
    start = 1'b1; len = 4'd1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd6; tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== {4'b1010, 4'd6}) begin
      errors++; $display("FAIL after_reset_run: got %b expected %b", obs, {4'b1010, 4'd6});
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL after_reset_idle: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_overflow();
    test_zero_len();
    test_bubbles();
    test_backpressure();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
